// File: rtl/pipe_stage_skid.sv
// Pipeline stage register: valid/ready handshake, optional skid entry, flush bubble, stall/flush counters.
// Latency 1 cycle in to out; SKID=1 registers in_ready, SKID=0 passes downstream ready through combinationally.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    input  logic              stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              xfer_in;
    logic              xfer_out;

    assign out_valid = main_v;
    assign out_data  = main_d;
    assign xfer_in   = in_valid && in_ready;
    assign xfer_out  = main_v && out_ready && !stall;

    generate
        if (SKID != 0) begin : g_skid
            logic              skid_v;
            logic              rdy_q;
            logic [DATA_W-1:0] skid_d;

            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                    skid_v <= 1'b0;
                    skid_d <= '0;
                    rdy_q  <= 1'b1;
                end else if (!main_v || xfer_out) begin
                    // Main is free this edge; a parked skid entry always goes first.
                    if (skid_v) begin
                        main_d <= skid_d;
                        main_v <= 1'b1;
                        skid_v <= 1'b0;
                        rdy_q  <= 1'b1;
                    end else if (xfer_in) begin
                        main_d <= in_data;
                        main_v <= 1'b1;
                    end else begin
                        main_v <= 1'b0;
                    end
                end else if (xfer_in) begin
                    skid_d <= in_data;
                    skid_v <= 1'b1;
                    rdy_q  <= 1'b0;
                end
            end

            assign in_ready  = rdy_q;
            assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
        end else begin : g_noskid
            always_ff @(posedge clock) begin
                if (reset || flush) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                end else if (xfer_in) begin
                    main_d <= in_data;
                    main_v <= 1'b1;
                end else if (xfer_out) begin
                    main_v <= 1'b0;
                end
            end

            assign in_ready  = !main_v || xfer_out;
            assign occupancy = {1'b0, main_v};
        end
    endgenerate

    logic stall_hit;
    logic flush_hit;

    assign stall_hit = main_v && !xfer_out;
    assign flush_hit = flush && ((occupancy != 2'd0) || xfer_in);

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_hit && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_hit && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Drives one SKID=1/CNT_W=16 stage and one SKID=0/CNT_W=2 stage with shared stimulus and
// checks both against a queue-based model of the stage contents.
module tb_pipe_stage_skid;

    localparam int DW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          stall;
    logic          out_ready;

    logic          r1, ov1, r0, ov0;
    logic [DW-1:0] od1, od0;
    logic [1:0]    oc1, oc0;
    logic [15:0]   sc1, fc1;
    logic [1:0]    sc0, fc0;

    int tests = 0;
    int fails = 0;
    bit run   = 1'b0;

    logic [DW-1:0] mq [2][$];
    logic [DW-1:0] hold [2];
    int            scnt [2];
    int            fcnt [2];

    always #5 clock = ~clock;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(16)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
        .flush(flush), .stall(stall), .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(oc1), .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(0), .CNT_W(2)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
        .flush(flush), .stall(stall), .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(oc0), .stall_cnt(sc0), .flush_cnt(fc0)
    );

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s skid=%0d t=%0t got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Model: the stage is an ordered queue of capacity 2 (SKID=1) or 1 (SKID=0).
    always @(negedge clock) begin
        if (run) begin
            for (int k = 0; k < 2; k++) begin
                logic          a_rdy, a_ov, rel, rdy, acc;
                logic [DW-1:0] a_od, popped;
                logic [1:0]    a_oc;
                logic [15:0]   a_sc, a_fc;
                int            sz, smax;
                if (k == 1) begin
                    a_rdy = r1; a_ov = ov1; a_od = od1; a_oc = oc1; a_sc = sc1; a_fc = fc1;
                    smax  = 65535;
                end else begin
                    a_rdy = r0; a_ov = ov0; a_od = od0; a_oc = oc0;
                    a_sc  = {14'b0, sc0}; a_fc = {14'b0, fc0};
                    smax  = 3;
                end
                sz  = mq[k].size();
                rel = (sz > 0) && out_ready && !stall;
                rdy = (k == 1) ? (sz < 2) : ((sz == 0) || rel);
                acc = in_valid && rdy;

                chk("in_ready",  k, {31'b0, a_rdy}, {31'b0, rdy});
                chk("out_valid", k, {31'b0, a_ov}, {31'b0, (sz > 0)});
                chk("occupancy", k, {30'b0, a_oc}, sz);
                chk("out_data",  k, {16'b0, a_od}, {16'b0, hold[k]});
                chk("stall_cnt", k, {16'b0, a_sc}, scnt[k]);
                chk("flush_cnt", k, {16'b0, a_fc}, fcnt[k]);

                if (reset) begin
                    mq[k].delete();
                    hold[k] = '0;
                    scnt[k] = 0;
                    fcnt[k] = 0;
                end else begin
                    if ((sz > 0) && !rel && scnt[k] < smax) scnt[k]++;
                    if (rel) begin
                        popped = mq[k].pop_front();
                        chk("release_order", k, {16'b0, a_od}, {16'b0, popped});
                    end
                    if (flush) begin
                        if (((sz > 0) || acc) && fcnt[k] < smax) fcnt[k]++;
                        mq[k].delete();
                        hold[k] = '0;
                    end else begin
                        if (acc) mq[k].push_back(in_data);
                        if (mq[k].size() > 0) hold[k] = mq[k][0];
                    end
                end
            end
        end
    end

    task automatic step(input logic rs, input logic iv, input logic [DW-1:0] d,
                        input logic fl, input logic st, input logic ordy);
        @(posedge clock);
        #1;
        reset = rs; in_valid = iv; in_data = d; flush = fl; stall = st; out_ready = ordy;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            hold[k] = '0; scnt[k] = 0; fcnt[k] = 0;
        end
        reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; stall = 1'b0; out_ready = 1'b1;
        @(posedge clock);
        #1;
        run = 1'b1;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // back-to-back stream
        step(1'b0, 1'b1, 16'h1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h2, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 16'h3, 1'b0, 1'b0, 1'b1);
        idle(3);
        @(negedge clock);
        chk("stream_no_stall", 1, {16'b0, sc1}, 0);

        // stalled main fills the skid entry, then drains in order
        step(1'b0, 1'b1, 16'hA, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'hB, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // flush with both entries held and input offered
        step(1'b0, 1'b1, 16'h1A, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h1B, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'hC, 1'b1, 1'b1, 1'b1);
        idle(2);

        // flush and stall together with one entry
        step(1'b0, 1'b1, 16'h2A, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        idle(1);

        // long stall saturates the narrow counter
        step(1'b0, 1'b1, 16'h3A, 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        chk("stall_cnt_saturated", 0, {30'b0, sc0}, 3);
        idle(2);

        // reset overrides flush with a full stage
        step(1'b0, 1'b1, 16'h4A, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 16'h4B, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 16'h4C, 1'b1, 1'b1, 1'b1);
        idle(1);
        @(negedge clock);
        chk("reset_occ",   1, {30'b0, oc1}, 0);
        chk("reset_data",  1, {16'b0, od1}, 0);
        chk("reset_ready", 1, {31'b0, r1}, 1);
        chk("reset_fcnt",  1, {16'b0, fc1}, 0);

        repeat (3000) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 70,
                 DW'($urandom),
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 70);
        end

        idle(4);
        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
